// File: rtl/disp_scan_ctrl.sv
// Multiplexed N-digit 7-segment scanner with frame-synchronous shadow registers,
// per-digit decimal point/blank, leading-zero suppression and PWM brightness.
module disp_scan_ctrl #(
    parameter int N  = 4,
    parameter int D  = 16,
    parameter int BW = 4
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [4*N-1:0] digits,
    input  logic [N-1:0]   dp,
    input  logic [N-1:0]   blank,
    input  logic           lzs,
    input  logic [BW-1:0]  bright,
    output logic [N-1:0]   an,
    output logic [6:0]     seg,
    output logic           dp_out,
    output logic           frame
);

    localparam int AW = $clog2(N);

    logic [D-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [4*N-1:0] sh_digits_q, sh_digits_d;
    logic [N-1:0]   sh_dp_q, sh_dp_d;
    logic [N-1:0]   sh_blank_q, sh_blank_d;
    logic           sh_lzs_q, sh_lzs_d;
    logic           frame_q, frame_d;
    logic [N-1:0]   an_q, an_d;
    logic [6:0]     seg_q, seg_d;
    logic           dp_out_q, dp_out_d;

    logic           tick;
    logic           load;
    logic           zero_above;
    logic           pwm_on;
    logic           cur_dp;
    logic           cur_blank;
    logic           cur_supp;
    logic [N-1:0]   supp;
    logic [N-1:0]   sel;
    logic [3:0]     cur_digit;
    logic [BW-1:0]  phase;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Shadow registers reload only as the last digit's slot ends, so a frame never mixes old and new data.
    always_comb begin
        tick        = (cnt_q == '1);
        load        = tick && (addr_q == AW'(N - 1));
        cnt_d       = cnt_q + D'(1);
        addr_d      = addr_q;
        if (tick) begin
            addr_d = load ? '0 : addr_q + AW'(1);
        end
        sh_digits_d = load ? digits : sh_digits_q;
        sh_dp_d     = load ? dp     : sh_dp_q;
        sh_blank_d  = load ? blank  : sh_blank_q;
        sh_lzs_d    = load ? lzs    : sh_lzs_q;
        frame_d     = load;
    end

    always_comb begin
        zero_above = 1'b1;
        supp       = '0;
        for (int i = N - 1; i >= 0; i--) begin
            zero_above = zero_above && (sh_digits_q[4*i +: 4] == 4'h0);
            supp[i]    = sh_lzs_q && zero_above && (i != 0);
        end

        cur_digit = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b1;
        cur_supp  = 1'b0;
        sel       = '1;
        for (int i = 0; i < N; i++) begin
            if (addr_q == AW'(i)) begin
                cur_digit = sh_digits_q[4*i +: 4];
                cur_dp    = sh_dp_q[i];
                cur_blank = sh_blank_q[i];
                cur_supp  = supp[i];
                sel[i]    = 1'b0;
            end
        end

        phase  = cnt_q[D-1 -: BW];
        pwm_on = (bright == '1) || (phase < bright);

        // A suppressed digit keeps its anode only to show a requested decimal point.
        an_d     = '1;
        seg_d    = 7'h7F;
        dp_out_d = 1'b1;
        if (pwm_on && !cur_blank) begin
            if (!cur_supp) begin
                an_d     = sel;
                seg_d    = hex7(cur_digit);
                dp_out_d = ~cur_dp;
            end else if (cur_dp) begin
                an_d     = sel;
                dp_out_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q       <= '0;
            addr_q      <= '0;
            sh_digits_q <= '0;
            sh_dp_q     <= '0;
            sh_blank_q  <= '1;
            sh_lzs_q    <= 1'b0;
            frame_q     <= 1'b0;
            an_q        <= '1;
            seg_q       <= 7'h7F;
            dp_out_q    <= 1'b1;
        end else begin
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            sh_digits_q <= sh_digits_d;
            sh_dp_q     <= sh_dp_d;
            sh_blank_q  <= sh_blank_d;
            sh_lzs_q    <= sh_lzs_d;
            frame_q     <= frame_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_out_q    <= dp_out_d;
        end
    end

    assign an     = an_q;
    assign seg    = seg_q;
    assign dp_out = dp_out_q;
    assign frame  = frame_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Bench for disp_scan_ctrl: three instances (N=4/D=2, N=4/D=4, N=6/D=2) checked
// cycle by cycle against a slot-timing model plus directed frame checks.
module tb_disp_scan_ctrl;

    localparam logic [6:0] HEX_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] digits4;
    logic [3:0]  dp4;
    logic [3:0]  blank4;
    logic        lzs4;
    logic [1:0]  brightA;
    logic [1:0]  brightB;
    logic [23:0] digits6;
    logic [5:0]  dp6;
    logic [5:0]  blank6;

    logic [3:0]  anA, anB;
    logic [5:0]  anC;
    logic [6:0]  segA, segB, segC;
    logic        dpA, dpB, dpC;
    logic        frameA, frameB, frameC;

    int checks = 0;
    int errors = 0;

    logic [18:0] expQ[$];
    int          tCnt    [3];
    logic [31:0] shDig   [3];
    logic [7:0]  shDp    [3];
    logic [7:0]  shBlank [3];
    logic        shLzs   [3];
    logic [31:0] mDig;
    logic [7:0]  mDp, mBlk;
    logic        mLz;
    int          mBr;
    logic [16:0] mExp;
    logic [18:0] popped;

    always #5 clk = ~clk;

    disp_scan_ctrl #(.N(4), .D(2), .BW(2)) dutA (
        .clk(clk), .reset_n(reset_n), .digits(digits4), .dp(dp4), .blank(blank4),
        .lzs(lzs4), .bright(brightA), .an(anA), .seg(segA), .dp_out(dpA), .frame(frameA)
    );

    disp_scan_ctrl #(.N(4), .D(4), .BW(2)) dutB (
        .clk(clk), .reset_n(reset_n), .digits(digits4), .dp(dp4), .blank(blank4),
        .lzs(lzs4), .bright(brightB), .an(anB), .seg(segB), .dp_out(dpB), .frame(frameB)
    );

    disp_scan_ctrl #(.N(6), .D(2), .BW(2)) dutC (
        .clk(clk), .reset_n(reset_n), .digits(digits6), .dp(dp6), .blank(blank6),
        .lzs(1'b0), .bright(brightA), .an(anC), .seg(segC), .dp_out(dpC), .frame(frameC)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] nDig, input logic [3:0] nDp, input logic nLz);
        digits4 = nDig;
        dp4     = nDp;
        lzs4    = nLz;
    endtask

    // Expected {an(8, unused bits high), seg, dp_out, frame} one cycle after an edge,
    // derived from the number of active edges since reset release.
    function automatic logic [16:0] modelOut(input int n, input int d, input int t,
                                             input logic [31:0] dig, input logic [7:0] dpv,
                                             input logic [7:0] blk, input logic lz, input int br);
        int         p, cnt, slot, phase;
        logic       zeroAbove, sup, on, frameNext, dpo;
        logic [7:0] anv;
        logic [6:0] sg;
        logic [3:0] dv;
        p         = 1 << d;
        cnt       = t % p;
        slot      = (t / p) % n;
        phase     = cnt >> (d - 2);
        on        = (br == 3) || (phase < br);
        zeroAbove = 1'b1;
        for (int j = slot; j < n; j++) begin
            if (dig[4*j +: 4] != 4'h0) zeroAbove = 1'b0;
        end
        sup = lz && zeroAbove && (slot != 0);
        anv = 8'hFF;
        sg  = 7'h7F;
        dpo = 1'b1;
        dv  = dig[4*slot +: 4];
        if (on && !blk[slot]) begin
            if (!sup) begin
                anv[slot] = 1'b0;
                sg        = HEX_TABLE[dv];
                dpo       = !dpv[slot];
            end else if (dpv[slot]) begin
                anv[slot] = 1'b0;
                dpo       = 1'b0;
            end
        end
        frameNext = (cnt == p - 1) && (slot == n - 1);
        return {anv, sg, dpo, frameNext};
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                expQ.delete();
                for (int i = 0; i < 3; i++) begin
                    tCnt[i]    = 0;
                    shDig[i]   = '0;
                    shDp[i]    = '0;
                    shBlank[i] = 8'hFF;
                    shLzs[i]   = 1'b0;
                end
            end else begin
                for (int i = 0; i < 3; i++) begin
                    case (i)
                        0, 1: begin
                            mDig = {16'h0, digits4};
                            mDp  = {4'h0, dp4};
                            mBlk = {4'h0, blank4};
                            mLz  = lzs4;
                            mBr  = (i == 0) ? int'(brightA) : int'(brightB);
                        end
                        default: begin
                            mDig = {8'h0, digits6};
                            mDp  = {2'b0, dp6};
                            mBlk = {2'b0, blank6};
                            mLz  = 1'b0;
                            mBr  = int'(brightA);
                        end
                    endcase
                    mExp = modelOut((i == 2) ? 6 : 4, (i == 1) ? 4 : 2, tCnt[i],
                                    shDig[i], shDp[i], shBlank[i], shLzs[i], mBr);
                    expQ.push_back({2'(i), mExp});
                    if (mExp[0]) begin
                        shDig[i]   = mDig;
                        shDp[i]    = mDp;
                        shBlank[i] = mBlk;
                        shLzs[i]   = mLz;
                    end
                    tCnt[i]++;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (reset_n) begin
                while (expQ.size() > 0) begin
                    popped = expQ.pop_front();
                    case (popped[18:17])
                        2'd0:    checkOutput("scoreA", 32'({4'hF, anA, segA, dpA, frameA}), 32'(popped[16:0]));
                        2'd1:    checkOutput("scoreB", 32'({4'hF, anB, segB, dpB, frameB}), 32'(popped[16:0]));
                        default: checkOutput("scoreC", 32'({2'b11, anC, segC, dpC, frameC}), 32'(popped[16:0]));
                    endcase
                end
            end
        end
    end

    task automatic waitFrame(input int inst, output int n);
        logic f;
        n = 0;
        f = 1'b0;
        while (!f && n < 500) begin
            @(negedge clk);
            n++;
            f = (inst == 0) ? frameA : (inst == 1) ? frameB : frameC;
        end
        if (!f) checkOutput("frameTimeout", 32'(0), 32'(1));
    endtask

    // Checks the 16 cycles of one A frame; next inputs are applied while slot 1 is showing.
    task automatic scanFrameA(input logic [15:0] expAn, input logic [27:0] expSeg, input logic [3:0] expDp,
                              input logic [15:0] nDig, input logic [3:0] nDp, input logic nLz);
        int s;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            s = (k - 1) / 4;
            checkOutput("anA", 32'(anA), 32'(expAn[4*s +: 4]));
            checkOutput("segA", 32'(segA), 32'(expSeg[7*s +: 7]));
            checkOutput("dpA", 32'(dpA), 32'(expDp[s]));
            checkOutput("frameA", 32'(frameA), 32'(k == 16));
            if (k == 5) begin
                #1;
                applyStimulus(nDig, nDp, nLz);
            end
        end
    endtask

    initial begin
        int         n, lowCnt, s;
        logic [5:0] one6;
        logic [5:0] expAnC;
        one6    = 6'd1;
        applyStimulus(16'h1234, 4'h0, 1'b0);
        blank4  = 4'h0;
        brightA = 2'd3;
        brightB = 2'd3;
        digits6 = 24'h0A5F31;
        dp6     = 6'b000001;
        blank6  = 6'b000100;

        #12;
        checkOutput("rstAn", 32'(anA), 32'h0000000F);
        checkOutput("rstSeg", 32'(segA), 32'h7F);
        checkOutput("rstDp", 32'(dpA), 32'(1));
        checkOutput("rstFrame", 32'(frameA), 32'(0));
        @(negedge clk);
        #1 reset_n = 1'b1;

        waitFrame(0, n);
        checkOutput("firstFrameA", 32'(n), 32'(16));
        scanFrameA(16'h7BDE, {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF, 16'hABCD, 4'h0, 1'b0);
        scanFrameA(16'h7BDE, {7'h08, 7'h03, 7'h46, 7'h21}, 4'hF, 16'h0050, 4'h0, 1'b1);
        scanFrameA(16'hFFDE, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'hF, 16'h0000, 4'b1000, 1'b1);
        scanFrameA(16'h7FFE, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b0111, 16'h1234, 4'h0, 1'b0);

        for (int b = 0; b < 4; b++) begin
            #1 brightB = 2'(b);
            waitFrame(1, n);
            lowCnt = 0;
            repeat (64) begin
                @(negedge clk);
                if (!anB[0]) lowCnt++;
            end
            checkOutput("brightSweep", 32'(lowCnt), 32'((b == 3) ? 16 : 4 * b));
        end

        waitFrame(2, n);
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            s      = (k - 1) / 4;
            expAnC = (s == 2) ? 6'h3F : ~(one6 << s);
            checkOutput("anC", 32'(anC), 32'(expAnC));
            checkOutput("dpC", 32'(dpC), 32'(s != 0));
            checkOutput("frameC", 32'(frameC), 32'(k == 24));
        end

        waitFrame(0, n);
        repeat (9) @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        checkOutput("midRstAn", 32'(anA), 32'h0000000F);
        checkOutput("midRstSeg", 32'(segA), 32'h7F);
        checkOutput("midRstDp", 32'(dpA), 32'(1));
        checkOutput("midRstFrame", 32'(frameA), 32'(0));
        @(negedge clk);
        checkOutput("heldRstAn", 32'(anA), 32'h0000000F);
        #1 reset_n = 1'b1;
        waitFrame(0, n);
        checkOutput("frameAfterRst", 32'(n), 32'(16));
        scanFrameA(16'h7BDE, {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF, 16'h1234, 4'h0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
